// File: rtl/writeback_arbiter_l3_pkg.sv
// Shared types for the writeback arbiter: the writeback message layout,
// the stall-lock state encoding and a helper that sizes the message bus.
package writeback_arbiter_l3_pkg;

    localparam int unsigned SEQ_NUM_BITS   = 5;
    localparam int unsigned PHYS_ADDR_BITS = 6;

    typedef struct packed {
        logic [31:0]               pc;
        logic [SEQ_NUM_BITS-1:0]   seq_num;
        logic [4:0]                waddr;
        logic [31:0]               wdata;
        logic                      wen;
        logic [PHYS_ADDR_BITS-1:0] preg;
        logic [PHYS_ADDR_BITS-1:0] ppreg;
    } wb_msg_t;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    // Fixed fields (pc, waddr, wdata, wen) are 70 bits; the rest scale.
    function automatic int unsigned wb_msg_bits(input int unsigned seq_bits,
                                                input int unsigned phys_bits);
        return 32'd70 + seq_bits + 32'd2 * phys_bits;
    endfunction

endpackage

// File: rtl/writeback_arbiter_l3_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer,
// or the locked index when a stall has pinned the grant.
module rr_arbiter #(
    parameter int unsigned p_width = 4,
    localparam int unsigned IW = (p_width > 1) ? $clog2(p_width) : 1
) (
    input  logic [p_width-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    input  logic               i_lock,
    input  logic [IW-1:0]      i_lock_idx,
    output logic [p_width-1:0] o_grant,
    output logic [IW-1:0]      o_grant_idx
);

    logic        w_found;
    int unsigned w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = 0;
        if (i_lock) begin
            o_grant[i_lock_idx] = 1'b1;
            o_grant_idx         = i_lock_idx;
        end else begin
            for (int unsigned k = 0; k < p_width; k++) begin
                w_idx = 32'(i_ptr) + k;
                if (w_idx >= p_width) begin
                    w_idx = w_idx - p_width;
                end
                if (!w_found && i_req[IW'(w_idx)]) begin
                    w_found              = 1'b1;
                    o_grant[IW'(w_idx)]  = 1'b1;
                    o_grant_idx          = IW'(w_idx);
                end
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter_l3.sv
// Merges per-unit completion messages into one writeback stream: one-entry
// slot per unit, round-robin drain, grant pinned while writeback stalls.
module writeback_arbiter_l3
    import writeback_arbiter_l3_pkg::*;
#(
    parameter int unsigned p_num_units      = 4,
    parameter int unsigned p_seq_num_bits   = 5,
    parameter int unsigned p_phys_addr_bits = 6,
    localparam int unsigned MB = wb_msg_bits(p_seq_num_bits, p_phys_addr_bits),
    localparam int unsigned UW = (p_num_units > 1) ? $clog2(p_num_units) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [p_num_units-1:0]    x_val,
    output logic [p_num_units-1:0]    x_rdy,
    input  logic [p_num_units*MB-1:0] x_msg,
    output logic                      w_val,
    input  logic                      w_rdy,
    output logic [MB-1:0]             w_msg,
    output logic [UW-1:0]             w_unit
);

    lock_state_t             r_state;
    lock_state_t             w_state_nxt;
    logic [UW-1:0]           r_lock_idx;
    logic [UW-1:0]           w_lock_idx_nxt;
    logic [UW-1:0]           r_ptr;
    logic [UW-1:0]           w_ptr_nxt;
    logic [UW-1:0]           w_grant_idx;
    logic [p_num_units-1:0]  w_grant;
    logic [p_num_units-1:0]  w_pop;
    logic [p_num_units-1:0]  w_in_val;
    logic [MB-1:0]           w_in_msg [p_num_units];
    logic                    w_fire;
    logic                    w_lock;

    assign w_lock = (r_state == ST_LOCKED);

    rr_arbiter #(
        .p_width (p_num_units)
    ) u_rr_arbiter (
        .i_req       (w_in_val),
        .i_ptr       (r_ptr),
        .i_lock      (w_lock),
        .i_lock_idx  (r_lock_idx),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign w_val  = |w_in_val;
    assign w_msg  = w_in_msg[w_grant_idx];
    assign w_unit = w_grant_idx;
    assign w_fire = w_val & w_rdy;
    assign w_pop  = {p_num_units{w_fire}} & w_grant;

    // One-entry slot per unit; a pop and a refill may share a cycle.
    for (genvar gi = 0; gi < p_num_units; gi++) begin : g_slot
        logic          r_val;
        logic [MB-1:0] r_msg;

        assign x_rdy[gi]    = ~r_val | w_pop[gi];
        assign w_in_val[gi] = r_val;
        assign w_in_msg[gi] = r_msg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_val <= 1'b0;
                r_msg <= '0;
            end else if (x_val[gi] && x_rdy[gi]) begin
                r_val <= 1'b1;
                r_msg <= x_msg[gi*MB +: MB];
            end else if (w_pop[gi]) begin
                r_val <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_OPEN;
            r_lock_idx <= '0;
            r_ptr      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_idx <= w_lock_idx_nxt;
            r_ptr      <= w_ptr_nxt;
        end
    end

    // Pointer advances past the winner; a stall pins the current winner.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_idx_nxt = r_lock_idx;
        w_ptr_nxt      = r_ptr;
        if (w_fire) begin
            w_ptr_nxt = (w_grant_idx == UW'(p_num_units - 1)) ? '0 : w_grant_idx + UW'(1);
        end
        case (r_state)
            ST_OPEN: begin
                if (w_val && !w_rdy) begin
                    w_state_nxt    = ST_LOCKED;
                    w_lock_idx_nxt = w_grant_idx;
                end
            end
            ST_LOCKED: begin
                if (w_fire) begin
                    w_state_nxt = ST_OPEN;
                end
            end
            default: w_state_nxt = ST_OPEN;
        endcase
    end

endmodule

// File: tb/tb_writeback_arbiter_l3.sv
// Bench for writeback_arbiter_l3: directed scenarios plus random traffic,
// every cycle compared against a slot/pointer/hold reference model.
module tb_writeback_arbiter_l3;
    import writeback_arbiter_l3_pkg::*;

    localparam int N  = 4;
    localparam int MB = $bits(wb_msg_t);
    localparam int UW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    x_val;
    logic [N-1:0]    x_rdy;
    logic [N*MB-1:0] x_msg;
    logic            w_val;
    logic            w_rdy;
    logic [MB-1:0]   w_msg;
    logic [UW-1:0]   w_unit;

    writeback_arbiter_l3 #(
        .p_num_units      (N),
        .p_seq_num_bits   (5),
        .p_phys_addr_bits (6)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .x_val  (x_val),
        .x_rdy  (x_rdy),
        .x_msg  (x_msg),
        .w_val  (w_val),
        .w_rdy  (w_rdy),
        .w_msg  (w_msg),
        .w_unit (w_unit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: slot contents, next-search start, held winner
    logic          m_val [N];
    logic [MB-1:0] m_msg [N];
    int            m_ptr;
    int            m_held;
    int            m_wait [N];
    int            m_max_wait;

    logic          obs_val;
    logic [UW-1:0] obs_unit;
    logic [MB-1:0] obs_msg;
    logic [N-1:0]  obs_rdy;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < N; u++) begin
            m_val[u]  = 1'b0;
            m_msg[u]  = '0;
            m_wait[u] = 0;
        end
        m_ptr  = 0;
        m_held = -1;
    endtask

    function automatic int exp_grant();
        if (m_held >= 0) return m_held;
        for (int k = 0; k < N; k++) begin
            if (m_val[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic wb_msg_t mk_msg(input int seq);
        wb_msg_t m;
        m.pc      = $urandom;
        m.seq_num = 5'(seq);
        m.waddr   = 5'($urandom);
        m.wdata   = $urandom;
        m.wen     = 1'($urandom);
        m.preg    = 6'($urandom);
        m.ppreg   = 6'($urandom);
        return m;
    endfunction

    task automatic set_msg(input int u, input wb_msg_t m);
        x_msg[u*MB +: MB] = m;
    endtask

    // Called at the falling edge with inputs already driven: check, clock, update model.
    task automatic tick();
        int           g;
        logic         ev;
        logic [N-1:0] er;
        #1;
        g  = exp_grant();
        ev = (g >= 0);
        for (int u = 0; u < N; u++) er[u] = !m_val[u] || (ev && w_rdy && g == u);
        obs_val  = w_val;
        obs_unit = w_unit;
        obs_msg  = w_msg;
        obs_rdy  = x_rdy;
        chk("w_val", w_val, ev);
        chk("x_rdy", x_rdy, er);
        if (ev) begin
            chk("w_unit", w_unit, g);
            chk("w_msg", w_msg, m_msg[g]);
        end
        @(posedge clk);
        if (ev && w_rdy) begin
            for (int u = 0; u < N; u++) begin
                if (u != g && m_val[u]) begin
                    m_wait[u]++;
                    if (m_wait[u] > m_max_wait) m_max_wait = m_wait[u];
                end
            end
            m_wait[g] = 0;
            m_val[g]  = 1'b0;
            m_ptr     = (g + 1) % N;
            m_held    = -1;
        end else if (ev) begin
            m_held = g;
        end
        for (int u = 0; u < N; u++) begin
            if (x_val[u] && er[u]) begin
                if (!m_val[u]) m_wait[u] = 0;
                m_val[u] = 1'b1;
                m_msg[u] = x_msg[u*MB +: MB];
            end
        end
        @(negedge clk);
    endtask

    wb_msg_t m3;
    wb_msg_t ms;
    wb_msg_t tmp;
    int      exp_order [3];

    initial begin
        m_max_wait = 0;
        model_reset();
        rst   = 1'b1;
        x_val = '0;
        x_msg = '0;
        w_rdy = 1'b0;
        #2;
        chk("rst_w_val", w_val, 1'b0);
        chk("rst_x_rdy", x_rdy, 4'b1111);
        chk("rst_w_unit", w_unit, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: single message from unit 2
        set_msg(2, mk_msg(3));
        x_val = 4'b0100;
        w_rdy = 1'b1;
        tick();
        chk("t1_latency", obs_val, 1'b0);
        x_val = '0;
        tick();
        tmp = obs_msg;
        chk("t1_unit", obs_unit, 2);
        chk("t1_seq", tmp.seq_num, 3);
        // bring the pointer back to 0
        set_msg(3, mk_msg(9));
        x_val = 4'b1000;
        tick();
        x_val = '0;
        tick();

        // 2: all units valid, continuous then drained
        for (int u = 0; u < N; u++) set_msg(u, mk_msg(u));
        x_val = 4'b1111;
        tick();
        for (int k = 0; k < 12; k++) begin
            for (int u = 0; u < N; u++) set_msg(u, mk_msg(4 + k));
            x_val = (k < 8) ? 4'b1111 : 4'b0000;
            tick();
            chk("t2_val", obs_val, 1'b1);
            chk("t2_order", obs_unit, k % N);
        end

        // 3: stall with a higher-priority late arrival
        set_msg(1, mk_msg(20));
        x_val = 4'b0010;
        tick();
        set_msg(1, mk_msg(21));
        m3 = mk_msg(23);
        set_msg(3, m3);
        x_val = 4'b1010;
        tick();
        chk("t3_pre_unit", obs_unit, 1);
        w_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            x_val = (c == 1) ? 4'b0100 : 4'b0000;
            if (c == 1) set_msg(2, mk_msg(22));
            tick();
            chk("t3_stall_unit", obs_unit, 3);
            chk("t3_stall_msg", obs_msg, m3);
        end
        x_val = '0;
        w_rdy = 1'b1;
        exp_order[0] = 3;
        exp_order[1] = 1;
        exp_order[2] = 2;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t3_order", obs_unit, exp_order[c]);
        end
        tick();
        chk("t3_empty", obs_val, 1'b0);

        // 4: unit 1 streams back to back
        for (int k = 0; k < 9; k++) begin
            x_val = (k < 8) ? 4'b0010 : 4'b0000;
            if (k < 8) set_msg(1, mk_msg(k));
            tick();
            tmp = obs_msg;
            if (k < 8) chk("t4_rdy", obs_rdy[1], 1'b1);
            if (k >= 1) begin
                chk("t4_val", obs_val, 1'b1);
                chk("t4_seq", tmp.seq_num, k - 1);
            end
        end

        // 5: store passes through untouched
        ms       = mk_msg(17);
        ms.wen   = 1'b0;
        ms.wdata = 32'hDEADBEEF;
        set_msg(0, ms);
        x_val = 4'b0001;
        tick();
        x_val = '0;
        tick();
        tmp = obs_msg;
        chk("t5_msg", obs_msg, ms);
        chk("t5_wen", tmp.wen, 1'b0);
        chk("t5_wdata", tmp.wdata, 32'hDEADBEEF);

        // 6: reset with three slots full
        for (int u = 0; u < 3; u++) set_msg(u, mk_msg(u + 24));
        x_val = 4'b0111;
        w_rdy = 1'b0;
        tick();
        x_val = '0;
        #2;
        chk("t6_full", w_val, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_async_w_val", w_val, 1'b0);
        chk("t6_async_x_rdy", x_rdy, 4'b1111);
        model_reset();
        @(negedge clk);
        rst   = 1'b0;
        w_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_no_stale", obs_val, 1'b0);
        end

        // random traffic
        m_max_wait = 0;
        for (int c = 0; c < 600; c++) begin
            x_val = 4'($urandom);
            for (int u = 0; u < N; u++) set_msg(u, mk_msg(int'($urandom_range(0, 31))));
            w_rdy = ($urandom_range(0, 9) < 7);
            tick();
        end
        x_val = '0;
        w_rdy = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        chk("starvation_bound", (m_max_wait <= N - 1), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
